fpu_rsp_monitor: RTL

Synthesizable receive-side monitor for the pfpu32 execute interface. It captures each issued FPU operation (opcode, operands, rounding) into an in-flight tag FIFO. It pairs each one with the next arith/compare completion the FPU produces, then emits one completed transaction record per operation over a valid/ready stream to the scoreboard. It is the collecting end of the stimulus path that drives the FPU inputs, and it flags protocol errors: orphan results, lost results, overflow and timeout.

---
 rtl/fpu_mon_pkg.sv | 28 ++
 rtl/fpu_rsp_monitor_if.sv | 49 ++++
 rtl/fpu_mon_fifo.sv | 49 ++++
 rtl/fpu_rsp_monitor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_mon_pkg.sv
// Shared types for the FPU response monitor: error bit positions, FSM states, in-flight entry layout.
// Entry field widths follow the monitor's default parameterisation.
package fpu_mon_pkg;

  localparam int ERR_ISS_OVF = 0;
  localparam int ERR_ORPHAN  = 1;
  localparam int ERR_REC_OVF = 2;
  localparam int ERR_TIMEOUT = 3;

  localparam int OP_W_DEF    = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int STAMP_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W_DEF-1:0]    op;
    logic [DATA_W_DEF-1:0]  opa;
    logic [DATA_W_DEF-1:0]  opb;
    logic [1:0]             rnd;
    logic [STAMP_W_DEF-1:0] stamp;
  } iss_entry_t;

endpackage

// File: rtl/fpu_rsp_monitor_if.sv
// Issue/completion/record bundle between the FPU stimulus side (master) and the monitor (slave).
// Record stream is valid/ready; issue and completion inputs have no backpressure.
interface fpu_rsp_monitor_if #(
  parameter int OP_W    = 8,
  parameter int DATA_W  = 32,
  parameter int CSR_W   = 11,
  parameter int STAMP_W = 16
);
  logic              iss_execute;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_opa;
  logic [DATA_W-1:0] iss_opb;
  logic [1:0]        iss_rnd;
  logic              flush;
  logic [DATA_W-1:0] fpu_result;
  logic              fpu_arith_valid;
  logic              fpu_cmp_flag;
  logic              fpu_cmp_valid;
  logic [CSR_W-1:0]  fpu_fpcsr;

  logic               rec_valid;
  logic               rec_ready;
  logic [OP_W-1:0]    rec_op;
  logic [DATA_W-1:0]  rec_opa;
  logic [DATA_W-1:0]  rec_opb;
  logic [1:0]         rec_rnd;
  logic [DATA_W-1:0]  rec_result;
  logic               rec_cmp;
  logic               rec_cmp_flag;
  logic [CSR_W-1:0]   rec_fpcsr;
  logic [STAMP_W-1:0] rec_latency;

  modport master (
    output iss_execute, iss_op, iss_opa, iss_opb, iss_rnd, flush,
    output fpu_result, fpu_arith_valid, fpu_cmp_flag, fpu_cmp_valid, fpu_fpcsr,
    output rec_ready,
    input  rec_valid, rec_op, rec_opa, rec_opb, rec_rnd, rec_result,
    input  rec_cmp, rec_cmp_flag, rec_fpcsr, rec_latency
  );

  modport slave (
    input  iss_execute, iss_op, iss_opa, iss_opb, iss_rnd, flush,
    input  fpu_result, fpu_arith_valid, fpu_cmp_flag, fpu_cmp_valid, fpu_fpcsr,
    input  rec_ready,
    output rec_valid, rec_op, rec_opa, rec_opb, rec_rnd, rec_result,
    output rec_cmp, rec_cmp_flag, rec_fpcsr, rec_latency
  );

endinterface

// File: rtl/fpu_mon_fifo.sv
// Synchronous DEPTH-entry FIFO, combinational head, 1-cycle push-to-head; flush empties on the edge.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module fpu_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // When full the write lands in the slot the pop is vacating.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fpu_rsp_monitor.sv
// Pairs each issued FPU op with its next completion and emits one record (1-cycle latency); sticky err -> HALT.
// Record held while rec_ready low; a completion arriving then is dropped and flagged. FPU_MON_STATS_EN adds counters.
module fpu_rsp_monitor
  import fpu_mon_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int OP_W    = OP_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CSR_W   = 11,
  parameter int TIMEOUT = 64,
  parameter int STAMP_W = STAMP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  fpu_rsp_monitor_if.slave  bus,
  output logic [3:0]        err,
  input  logic              err_clr,
  output logic              busy
`ifdef FPU_MON_STATS_EN
  ,
  output logic [31:0]        stat_arith,
  output logic [31:0]        stat_cmp,
  output logic [STAMP_W-1:0] stat_max_lat
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [STAMP_W-1:0] TMO = STAMP_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [STAMP_W-1:0] stamp_q;
  logic [STAMP_W-1:0] age;
  logic [3:0]         err_q, err_set;
  iss_entry_t         push_ent, head_ent;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_full, fifo_empty;
  logic               cpl, iss_req, halt_clr, fifo_clr, push, pop, tmo;
  logic               last_pop, rec_en, cand, rec_load;

  logic               rec_vld_q, rec_cmp_q, rec_flag_q;
  logic [OP_W-1:0]    rec_op_q;
  logic [DATA_W-1:0]  rec_opa_q, rec_opb_q, rec_res_q;
  logic [1:0]         rec_rnd_q;
  logic [CSR_W-1:0]   rec_csr_q;
  logic [STAMP_W-1:0] rec_lat_q;

  assign cpl      = bus.fpu_arith_valid | bus.fpu_cmp_valid;
  assign iss_req  = bus.iss_execute && (bus.iss_op != '0);
  assign halt_clr = err_clr && (state_q == HALT);
  assign fifo_clr = bus.flush | halt_clr;
  assign age      = stamp_q - head_ent.stamp;
  // A completion in the same cycle the head reaches its limit still counts as on time.
  assign tmo      = !fifo_empty && !cpl && (age >= TMO);
  assign pop      = (cpl && !fifo_empty) || tmo;
  assign push     = iss_req && !fifo_clr;
  assign last_pop = pop && !push && (fifo_cnt == CW'(1));
  assign cand     = cpl && !fifo_empty && rec_en;
  assign rec_load = cand && (!rec_vld_q || bus.rec_ready);

  always_comb begin
    err_set              = '0;
    err_set[ERR_ISS_OVF] = push && fifo_full && !pop;
    err_set[ERR_ORPHAN]  = cpl && fifo_empty;
    err_set[ERR_REC_OVF] = cand && rec_vld_q && !bus.rec_ready;
    err_set[ERR_TIMEOUT] = tmo;
  end

  assign push_ent = '{op: bus.iss_op, opa: bus.iss_opa, opb: bus.iss_opb,
                      rnd: bus.iss_rnd, stamp: stamp_q};

  fpu_mon_fifo #(
    .WIDTH ($bits(iss_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (fifo_clr),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (|err_set) begin
      state_d = HALT;
    end else begin
      case (state_q)
        IDLE:    if (push) state_d = PEND;
        PEND:    if (bus.flush || last_pop) state_d = IDLE;
        HALT:    if (err_clr) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rec_en = (state_q != HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stamp_q <= '0;
      err_q   <= '0;
    end else begin
      stamp_q <= stamp_q + 1'b1;
      err_q   <= (err_clr ? 4'b0 : err_q) | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rec_vld_q  <= 1'b0;
      rec_cmp_q  <= 1'b0;
      rec_flag_q <= 1'b0;
      rec_op_q   <= '0;
      rec_opa_q  <= '0;
      rec_opb_q  <= '0;
      rec_rnd_q  <= '0;
      rec_res_q  <= '0;
      rec_csr_q  <= '0;
      rec_lat_q  <= '0;
    end else if (rec_load) begin
      rec_vld_q  <= 1'b1;
      rec_cmp_q  <= bus.fpu_cmp_valid;
      rec_flag_q <= bus.fpu_cmp_valid & bus.fpu_cmp_flag;
      rec_op_q   <= head_ent.op;
      rec_opa_q  <= head_ent.opa;
      rec_opb_q  <= head_ent.opb;
      rec_rnd_q  <= head_ent.rnd;
      rec_res_q  <= bus.fpu_arith_valid ? bus.fpu_result : '0;
      rec_csr_q  <= bus.fpu_fpcsr;
      rec_lat_q  <= age;
    end else if (bus.rec_ready) begin
      rec_vld_q  <= 1'b0;
    end
  end

`ifdef FPU_MON_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n || err_clr) begin
      stat_arith   <= '0;
      stat_cmp     <= '0;
      stat_max_lat <= '0;
    end else if (rec_load) begin
      if (bus.fpu_cmp_valid) begin
        if (stat_cmp != '1) stat_cmp <= stat_cmp + 1'b1;
      end else begin
        if (stat_arith != '1) stat_arith <= stat_arith + 1'b1;
      end
      if (age > stat_max_lat) stat_max_lat <= age;
    end
  end
`endif

  assign err              = err_q;
  assign busy             = !fifo_empty;
  assign bus.rec_valid    = rec_vld_q;
  assign bus.rec_op       = rec_op_q;
  assign bus.rec_opa      = rec_opa_q;
  assign bus.rec_opb      = rec_opb_q;
  assign bus.rec_rnd      = rec_rnd_q;
  assign bus.rec_result   = rec_res_q;
  assign bus.rec_cmp      = rec_cmp_q;
  assign bus.rec_cmp_flag = rec_flag_q;
  assign bus.rec_fpcsr    = rec_csr_q;
  assign bus.rec_latency  = rec_lat_q;

endmodule
